sync_transmitter: RTL and testbench
===================================

# sync_transmitter

Generates the board-to-board sync signal consumed by the downstream sync receivers on every transducer board. The block emits clean, fixed-width high pulses on `sync_out` either periodically, while enabled, or on demand from a one-shot trigger. It guarantees minimum high and low times so that every rising edge yields exactly one `sync_pulse` at a receiver after that receiver's 2-flop synchronizer. It sits in the master board's top level, beside the phase/emission controller that drives `enable` and `trigger`.

## Interface
- `PERIOD_CYCLES`, default 1250: clocks between rising edges in periodic mode (40 kHz at 50 MHz).
- `HIGH_CYCLES`, default 4: exact number of clocks `sync_out` is held high per pulse; minimum 2.
- `MIN_LOW_CYCLES`, default 4: minimum number of clocks `sync_out` is held low after each pulse; minimum 2.
- Elaboration-time check: `PERIOD_CYCLES >= HIGH_CYCLES + MIN_LOW_CYCLES + 1`; otherwise `$error`.
- `clk`, input, 1: the single clock. One clock; reset is synchronous and active-low.
- `rst_n`, input, 1: synchronous, active-low reset.
- `enable`, input, 1: periodic mode on while high.
- `trigger`, input, 1: single-cycle request for one pulse.
- `sync_out`, output, 1: registered line to the receivers.
- `sync_sent`, output, 1: one-cycle strobe, coincident with the first high cycle of `sync_out`.
- `busy`, output, 1: high while the FSM is not IDLE.
- `overrun`, output, 1: sticky; set when a trigger is dropped. Cleared only by reset.

## Operation
- Period counter `pcnt`, width `$clog2(PERIOD_CYCLES)`. While `enable`=1 it counts 0 to PERIOD_CYCLES-1 and wraps. While `enable`=0 it is held at 0.
- `launch` = (`enable` && `pcnt`==0) || `trigger` || `pending`. The first pulse is therefore issued on the first cycle `enable` is sampled high.
- FSM states:
  - IDLE: `sync_out`=0. On `launch`, go to HIGH; set `sync_out`<=1, `sync_sent`<=1, clear `pending`, and clear `hcnt`.
  - HIGH: `sync_out`=1. `hcnt` counts; after HIGH_CYCLES high cycles, go to GUARD with `sync_out`<=0.
  - GUARD: `sync_out`=0 for MIN_LOW_CYCLES cycles, then go to IDLE.
- A `trigger` sampled in HIGH or GUARD sets `pending`, which is one deep.
- A `trigger` while `pending` is already set is dropped and sets `overrun`.
- `trigger` coincident with a periodic launch in IDLE produces one pulse. Neither `pending` nor `overrun` is set.
- A periodic tick cannot occur outside IDLE, by construction of the parameter check.
- `enable` falling mid-pulse: the pulse completes with full high and guard times, and `pcnt` returns to 0.
- Reset values: `sync_out`=0, `sync_sent`=0, `busy`=0, `overrun`=0, `pending`=0, state IDLE, `pcnt`=0.

## Timing
- Latency: `launch` sampled at edge k puts `sync_out`=1 and `sync_sent`=1 after edge k+1.
- `sync_out` is high for exactly HIGH_CYCLES clocks and low for at least MIN_LOW_CYCLES clocks.
- Periodic mode: rising edges are exactly PERIOD_CYCLES apart, with no drift.
- A pending pulse starts one cycle after GUARD exits through IDLE. Minimum edge spacing is HIGH_CYCLES + MIN_LOW_CYCLES + 1.
- `sync_out` comes directly from a flop with no combinational path to the pin.
- `rst_n` low at any edge, including mid-HIGH: `sync_out`=0 after that edge.

## Structure
- Package `sync_pkg` holds:
  - typedef `sync_tx_state_t` (IDLE, HIGH, GUARD);
  - constants `SYNC_MIN_HIGH`=2 and `SYNC_MIN_LOW`=2, used by the parameter checks and shared with the receiver side.
- Sub-module `sync_period_timer` contains the `pcnt` counter. It has inputs `clk`, `rst_n` and `enable`, and output tick `at_zero`. The FSM stays in `sync_transmitter`.

## Test plan
Bench parameters: PERIOD=20, HIGH=4, LOW=4. Loop `sync_out` back into a sync receiver on the same clock.
- Reset: hold `rst_n`=0 for 5 cycles, then release with inputs at 0 → all outputs 0 and `busy`=0 for 50 cycles.
- Periodic mode: `enable`=1 for 100 cycles → 5 rising edges, spaced exactly 20 cycles apart, each high 4 cycles; 5 `sync_sent` strobes; 5 receiver `sync_pulse`s.
- Trigger during a pulse: single `trigger` in IDLE, then a second `trigger` 2 cycles into HIGH → two pulses with rising edges 9 cycles apart; `overrun`=0.
- Dropped trigger: three triggers at cycles 0, 2 and 3 → two pulses; `overrun`=1 from cycle 4 and stays 1.
- Simultaneous events: `trigger` on the same cycle as `enable` first goes high → one pulse; `pending`=0 after it.
- Mid-operation disruptions:
  - `enable` dropped 1 cycle after a rising edge → full 4-cycle high, then idle.
  - `rst_n`=0 mid-HIGH → `sync_out`=0 after that edge.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared definitions for the board-to-board sync transmitter and its receivers.
package sync_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        GUARD = 2'd2
    } sync_tx_state_t;

    localparam int SYNC_MIN_HIGH = 2;
    localparam int SYNC_MIN_LOW  = 2;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_period_timer.sv
// Free-running period counter; held at zero while periodic mode is off.
module sync_period_timer
    import sync_pkg::*;
#(
    parameter int PERIOD_CYCLES = 1250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic at_zero
);

    localparam int PW = cnt_width(PERIOD_CYCLES);
    localparam logic [PW-1:0] PCNT_LAST = PW'(PERIOD_CYCLES - 1);

    logic [PW-1:0] pcnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            pcnt_reg <= '0;
        end else if (pcnt_reg == PCNT_LAST) begin
            pcnt_reg <= '0;
        end else begin
            pcnt_reg <= pcnt_reg + 1'b1;
        end
    end

    assign at_zero = (pcnt_reg == '0);

endmodule

// File: rtl/sync_transmitter.sv
// Emits fixed-width sync pulses, periodically or on trigger, with guaranteed
// high and low times so each rising edge is seen once by a 2-flop receiver.
module sync_transmitter
    import sync_pkg::*;
#(
    parameter int PERIOD_CYCLES  = 1250,
    parameter int HIGH_CYCLES    = 4,
    parameter int MIN_LOW_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic trigger,
    output logic sync_out,
    output logic sync_sent,
    output logic busy,
    output logic overrun
);

    // The period must fit a full pulse plus its guard and the IDLE cycle.
    if (PERIOD_CYCLES < HIGH_CYCLES + MIN_LOW_CYCLES + 1) begin : g_bad_period
        $error("sync_transmitter: PERIOD_CYCLES too short for HIGH_CYCLES + MIN_LOW_CYCLES + 1");
    end
    if (HIGH_CYCLES < SYNC_MIN_HIGH) begin : g_bad_high
        $error("sync_transmitter: HIGH_CYCLES below receiver minimum");
    end
    if (MIN_LOW_CYCLES < SYNC_MIN_LOW) begin : g_bad_low
        $error("sync_transmitter: MIN_LOW_CYCLES below receiver minimum");
    end

    localparam int HW = cnt_width(HIGH_CYCLES);
    localparam int LW = cnt_width(MIN_LOW_CYCLES);
    localparam logic [HW-1:0] HCNT_LAST = HW'(HIGH_CYCLES - 1);
    localparam logic [LW-1:0] GCNT_LAST = LW'(MIN_LOW_CYCLES - 1);

    sync_tx_state_t state_reg;
    logic [HW-1:0]  hcnt_reg;
    logic [LW-1:0]  gcnt_reg;
    logic           pending_reg;
    logic           sync_out_reg;
    logic           sync_sent_reg;
    logic           overrun_reg;
    logic           at_zero;
    logic           launch;

    sync_period_timer #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .at_zero(at_zero)
    );

    assign launch = (enable && at_zero) || trigger || pending_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            hcnt_reg      <= '0;
            gcnt_reg      <= '0;
            pending_reg   <= 1'b0;
            sync_out_reg  <= 1'b0;
            sync_sent_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            sync_sent_reg <= 1'b0;

            // Triggers arriving mid-pulse queue one deep; any more are lost.
            if (trigger && state_reg != IDLE) begin
                if (pending_reg) begin
                    overrun_reg <= 1'b1;
                end else begin
                    pending_reg <= 1'b1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (launch) begin
                        state_reg     <= HIGH;
                        sync_out_reg  <= 1'b1;
                        sync_sent_reg <= 1'b1;
                        pending_reg   <= 1'b0;
                        hcnt_reg      <= '0;
                    end
                end
                HIGH: begin
                    if (hcnt_reg == HCNT_LAST) begin
                        state_reg    <= GUARD;
                        sync_out_reg <= 1'b0;
                        gcnt_reg     <= '0;
                    end else begin
                        hcnt_reg <= hcnt_reg + 1'b1;
                    end
                end
                GUARD: begin
                    if (gcnt_reg == GCNT_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        gcnt_reg <= gcnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    sync_out_reg <= 1'b0;
                end
            endcase
        end
    end

    assign sync_out  = sync_out_reg;
    assign sync_sent = sync_sent_reg;
    assign busy      = (state_reg != IDLE);
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_sync_transmitter.sv
// Directed bench for sync_transmitter with a looped-back 2-flop sync receiver.
module tb_sync_transmitter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic trigger = 1'b0;
    logic sync_out, sync_sent, busy, overrun;

    always #5 clk = ~clk;

    sync_transmitter #(
        .PERIOD_CYCLES (20),
        .HIGH_CYCLES   (4),
        .MIN_LOW_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .trigger  (trigger),
        .sync_out (sync_out),
        .sync_sent(sync_sent),
        .busy     (busy),
        .overrun  (overrun)
    );

    // Receiver model: 2-flop synchronizer plus rising-edge detector.
    logic rx_meta, rx_sync, rx_last, sync_pulse;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b0;
            rx_sync <= 1'b0;
            rx_last <= 1'b0;
        end else begin
            rx_meta <= sync_out;
            rx_sync <= rx_meta;
            rx_last <= rx_sync;
        end
    end
    assign sync_pulse = rx_sync & ~rx_last;

    typedef struct packed {
        logic en;
        logic trg;
        logic so;
        logic ss;
        logic by;
        logic ov;
    } vec_t;

    vec_t vecs[40];

    int n_checks = 0;
    int n_fail   = 0;

    int cyc, rises, sents, pulses, last_rise, run, high_total;
    logic prev_so;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        cyc = 0; rises = 0; sents = 0; pulses = 0;
        last_rise = -1; run = 0; high_total = 0;
        prev_so = sync_out;
    endtask

    // Advance n cycles, tracking edges; exp_space = 0 skips spacing checks.
    task automatic watch(input int n, input int exp_space);
        for (int i = 0; i < n; i++) begin
            tick();
            check("sent_on_rise", int'(sync_sent), int'(sync_out && !prev_so));
            if (sync_out && !prev_so) begin
                if (last_rise >= 0 && exp_space != 0)
                    check("edge_spacing", cyc - last_rise, exp_space);
                last_rise = cyc;
                rises++;
            end
            if (sync_out) begin
                run++;
                high_total++;
            end
            if (!sync_out && prev_so) begin
                check("high_width", run, 4);
                run = 0;
            end
            if (sync_sent) sents++;
            if (sync_pulse) pulses++;
            prev_so = sync_out;
            cyc++;
        end
    endtask

    initial begin
        logic [0:19] trg_a, trg_b, so_t, ss_t, by_t, ov_a, ov_b;
        trg_a = 20'b1010_0000_0000_0000_0000;
        trg_b = 20'b1011_0000_0000_0000_0000;
        so_t  = 20'b1111_0000_0111_1000_0000;
        ss_t  = 20'b1000_0000_0100_0000_0000;
        by_t  = 20'b1111_1111_0111_1111_1000;
        ov_a  = 20'b0000_0000_0000_0000_0000;
        ov_b  = 20'b0001_1111_1111_1111_1111;
        for (int i = 0; i < 20; i++) begin
            vecs[i]      = '{en: 1'b0, trg: trg_a[i], so: so_t[i], ss: ss_t[i], by: by_t[i], ov: ov_a[i]};
            vecs[i + 20] = '{en: 1'b0, trg: trg_b[i], so: so_t[i], ss: ss_t[i], by: by_t[i], ov: ov_b[i]};
        end

        // Reset held, then released with idle inputs.
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("reset_outputs", int'({sync_out, sync_sent, busy, overrun}), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("post_reset_idle", int'({sync_out, sync_sent, busy, overrun}), 0);
        end

        // Periodic mode for 100 cycles.
        clear_counts();
        enable = 1'b1;
        watch(100, 20);
        enable = 1'b0;
        watch(20, 20);
        check("periodic_rises", rises, 5);
        check("periodic_sent", sents, 5);
        check("periodic_rx_pulses", pulses, 5);
        check("periodic_high_total", high_total, 20);
        $display("periodic: rises=%0d sent=%0d rx_pulses=%0d", rises, sents, pulses);

        // Trigger in IDLE plus one during HIGH, then dropped-trigger case.
        for (int i = 0; i < 40; i++) begin
            enable  = vecs[i].en;
            trigger = vecs[i].trg;
            tick();
            check($sformatf("vec%0d_sync_out", i), int'(sync_out), int'(vecs[i].so));
            check($sformatf("vec%0d_sync_sent", i), int'(sync_sent), int'(vecs[i].ss));
            check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].by));
            check($sformatf("vec%0d_overrun", i), int'(overrun), int'(vecs[i].ov));
            $display("vec%0d: trg=%0b so=%0b ss=%0b busy=%0b ov=%0b",
                     i, trigger, sync_out, sync_sent, busy, overrun);
        end
        trigger = 1'b0;

        // Clear the sticky overrun before the remaining scenarios.
        rst_n = 1'b0;
        tick();
        check("overrun_cleared_by_reset", int'(overrun), 0);
        rst_n = 1'b1;
        tick();

        // Trigger coincident with the first enabled cycle.
        clear_counts();
        enable  = 1'b1;
        trigger = 1'b1;
        watch(1, 0);
        trigger = 1'b0;
        watch(14, 0);
        enable = 1'b0;
        watch(10, 0);
        check("simul_rises", rises, 1);
        check("simul_pending", int'(dut.pending_reg), 0);
        check("simul_overrun", int'(overrun), 0);
        $display("simultaneous: rises=%0d", rises);

        // Enable dropped one cycle after the rising edge.
        clear_counts();
        enable = 1'b1;
        watch(1, 0);
        enable = 1'b0;
        watch(24, 0);
        check("endrop_rises", rises, 1);
        check("endrop_high_total", high_total, 4);
        check("endrop_idle", int'(busy), 0);
        $display("enable_drop: rises=%0d high=%0d", rises, high_total);

        // Reset asserted mid-HIGH.
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        check("pre_reset_high", int'(sync_out), 1);
        rst_n = 1'b0;
        tick();
        check("midhigh_reset_sync_out", int'(sync_out), 0);
        check("midhigh_reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick();
        check("after_reset_low", int'(sync_out), 0);
        $display("reset_mid_high: sync_out=%0b busy=%0b", sync_out, busy);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
